sequential_divider: RTL

//  Unsigned iterative restoring divider. It is the inverse operation to the pipelined multiplier in the arithmetic unit.

---
 rtl/sequential_divider_if.sv | 44 ++++
 rtl/sequential_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider_if.sv
// ---------------------------------------------------------------------------
// sequential_divider_if
// Operand/result handshake bundle for the sequential divider.
// master: operand producer / result consumer.  slave: the divider itself.
// ---------------------------------------------------------------------------
interface sequential_divider_if #(
   parameter int WIDTH = 4
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output in_valid,
      output dividend,
      output divisor,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  quotient,
      input  remainder,
      input  div_zero
   );

   modport slave (
      input  in_valid,
      input  dividend,
      input  divisor,
      input  out_ready,
      output in_ready,
      output out_valid,
      output quotient,
      output remainder,
      output div_zero
   );

endinterface : sequential_divider_if

// File: rtl/sequential_divider.sv
// ---------------------------------------------------------------------------
// sequential_divider
// Unsigned iterative restoring divider, one quotient bit per enabled cycle.
// Operands arrive and results leave over valid/ready (sequential_divider_if).
// EN is a global clock enable: with EN=0 nothing in the block changes.
//
// Optional feature macro: DIV_ZERO_FAST_EN
//   defined   : a zero divisor jumps IDLE -> DONE on the accepting edge.
//   undefined : a zero divisor runs the normal WIDTH iterations, which
//               naturally yield quotient = all ones, remainder = dividend.
// ---------------------------------------------------------------------------
module sequential_divider #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,   // asynchronous, active low
   input  logic                 EN,
   sequential_divider_if.slave  bus
);

   localparam int                CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]     CNT_ZERO  = CW'(1'b0);
   localparam logic [CW-1:0]     CNT_ONE   = CW'(1'b1);
   localparam logic [CW-1:0]     CNT_LAST  = CW'(WIDTH);
   localparam logic [WIDTH-1:0]  ZERO_W    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]  ONES_W    = {WIDTH{1'b1}};
   localparam logic [WIDTH:0]    ZERO_R    = {(WIDTH+1){1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // FSM state
   state_t           r_state;
   state_t           w_state_nxt;

   // Working registers: r_n starts as the dividend and is shifted left each
   // iteration while quotient bits enter at the LSB, so after WIDTH
   // iterations it holds the quotient.
   logic [WIDTH-1:0] r_n;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH:0]   r_r;      // partial remainder, WIDTH+1 bits
   logic [CW-1:0]    r_cnt;

   // Registered interface outputs
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_zero;

   // Control strobes
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_iter;
   logic             w_finish;
   logic             w_fast_dz;

   // Datapath step
   logic [WIDTH:0]   w_r_shift;
   logic [WIDTH:0]   w_r_sub;
   logic             w_ge;
   logic [WIDTH:0]   w_r_nxt;

   // Handshake strobes and iteration control, all qualified by EN
   always_comb begin
      w_in_fire  = EN & bus.in_valid & r_in_ready;
      w_out_fire = EN & r_out_valid & bus.out_ready;
      w_iter     = EN & (r_state == ST_BUSY) & (r_cnt != CNT_LAST);
      w_finish   = EN & (r_state == ST_BUSY) & (r_cnt == CNT_LAST);
`ifdef DIV_ZERO_FAST_EN
      w_fast_dz  = w_in_fire & (bus.divisor == ZERO_W);
`else
      w_fast_dz  = 1'b0;
`endif
   end

   // Next-state decode; every state holds when its transfer condition is absent
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_fast_dz) begin
               w_state_nxt = ST_DONE;
            end else if (w_in_fire) begin
               w_state_nxt = ST_BUSY;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (w_finish) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (w_out_fire) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   // The stored remainder is always below D, so dropping r_r's MSB in the
   // shift loses nothing and R' never overflows WIDTH+1 bits.
   always_comb begin
      w_r_shift = (r_r << 1) | {ZERO_W, r_n[WIDTH-1]};
      w_ge      = (w_r_shift >= {1'b0, r_d});
      w_r_sub   = w_r_shift - {1'b0, r_d};
      if (w_ge) begin
         w_r_nxt = w_r_sub;
      end else begin
         w_r_nxt = w_r_shift;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else if (EN) begin
         r_state <= w_state_nxt;
      end
   end

   // Operand capture and iteration registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_n   <= ZERO_W;
         r_d   <= ZERO_W;
         r_r   <= ZERO_R;
         r_cnt <= CNT_ZERO;
      end else if (w_in_fire) begin
         r_n   <= bus.dividend;
         r_d   <= bus.divisor;
         r_r   <= ZERO_R;
         r_cnt <= CNT_ZERO;
      end else if (w_iter) begin
         r_n   <= {r_n[WIDTH-2:0], w_ge};
         r_r   <= w_r_nxt;
         r_cnt <= r_cnt + CNT_ONE;
      end else if (w_finish) begin
         r_cnt <= CNT_ZERO;
      end
   end

   // Registered handshake flags follow the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (EN) begin
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_DONE);
      end
   end

   // Result registers load only on DONE entry and hold until the next result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_quotient  <= ZERO_W;
         r_remainder <= ZERO_W;
         r_div_zero  <= 1'b0;
      end else if (w_fast_dz) begin
         r_quotient  <= ONES_W;
         r_remainder <= bus.dividend;
         r_div_zero  <= 1'b1;
      end else if (w_finish) begin
         r_quotient  <= r_n;
         r_remainder <= r_r[WIDTH-1:0];
         r_div_zero  <= (r_d == ZERO_W);
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
   assign bus.div_zero  = r_div_zero;

endmodule : sequential_divider
